// File: rtl/inert_chan_monitor.sv
// -----------------------------------------------------------------------------
// inert_chan_monitor
// Sequences inertial sensor calibration, then shows one of NUM_CH signed
// channels on the board LEDs, either as the live sample or as a held peak
// magnitude. The channel advances on a NEXT pulse or on a timed auto tick.
//
// Ports:
//   clk       clock
//   rst_n     asynchronous active-low reset
//   cal_done  calibration-complete level from the inertial interface
//   strt_cal  one-cycle calibration start pulse (registered)
//   vld       one-cycle strobe: new sample set on ch_data
//   ch_data   packed samples, channel k at [k*DATA_W +: DATA_W]
//   next      one-cycle advance request
//   auto_md   1 = timed auto-advance enabled (next still honoured)
//   pk_md     1 = show peak magnitude, 0 = show live sample
//   clr_pk    one-cycle clear of all peak registers
//   LED       displayed bit window (registered)
//   ch_idx    currently displayed channel (registered)
//   cal_busy  high while calibrating (registered)
// -----------------------------------------------------------------------------
module inert_chan_monitor #(
   parameter int NUM_CH   = 3,
   parameter int DATA_W   = 16,
   parameter int LED_W    = 8,
   parameter int LSB_SEL  = 1,
   parameter int AUTO_CYC = 50_000_000,
   localparam int IW      = $clog2((NUM_CH > 1) ? NUM_CH : 2)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     cal_done,
   output logic                     strt_cal,
   input  logic                     vld,
   input  logic [NUM_CH*DATA_W-1:0] ch_data,
   input  logic                     next,
   input  logic                     auto_md,
   input  logic                     pk_md,
   input  logic                     clr_pk,
   output logic [LED_W-1:0]         LED,
   output logic [IW-1:0]            ch_idx,
   output logic                     cal_busy
);

   localparam int CW = $clog2(AUTO_CYC);

   localparam logic [IW-1:0]     IDX_ZERO  = IW'(0);
   localparam logic [IW-1:0]     IDX_ONE   = IW'(1);
   localparam logic [IW-1:0]     IDX_LAST  = IW'(NUM_CH - 1);
   localparam logic [CW-1:0]     CNT_ZERO  = CW'(0);
   localparam logic [CW-1:0]     CNT_ONE   = CW'(1);
   localparam logic [CW-1:0]     CNT_LAST  = CW'(AUTO_CYC - 1);
   localparam logic [DATA_W-1:0] DATA_ZERO = DATA_W'(0);
   localparam logic [DATA_W-1:0] DATA_ONE  = DATA_W'(1);
   localparam logic [DATA_W-1:0] MOST_NEG  = {1'b1, {(DATA_W-1){1'b0}}};
   localparam logic [DATA_W-1:0] MOST_POS  = {1'b0, {(DATA_W-1){1'b1}}};
   localparam logic [LED_W-1:0]  LED_ZERO  = LED_W'(0);

   typedef enum logic [1:0] {
      ST_START = 2'd0,
      ST_CAL   = 2'd1,
      ST_SHOW  = 2'd2
   } state_t;

   // Magnitude of a two's-complement sample; the most negative value has no
   // positive counterpart, so it saturates to the largest positive value.
   function automatic logic [DATA_W-1:0] sat_abs(input logic [DATA_W-1:0] s);
      logic [DATA_W-1:0] r;
      if (s == MOST_NEG) begin
         r = MOST_POS;
      end else if (s[DATA_W-1]) begin
         r = (~s) + DATA_ONE;
      end else begin
         r = s;
      end
      return r;
   endfunction

   state_t            state_r, state_nxt_s;
   logic              show_s, enter_show_s;
   logic              tick_s, adv_s, clr_all_s;
   logic [CW-1:0]     cnt_r, cnt_nxt_s;
   logic [IW-1:0]     ch_idx_r, idx_nxt_s;
   logic [DATA_W-1:0] abs_s  [NUM_CH];
   logic [DATA_W-1:0] pk_r   [NUM_CH];
   // Only the displayed window of each live sample is ever observable, so
   // just that window is stored.
   logic [LED_W-1:0]  live_r [NUM_CH];
   logic [LED_W-1:0]  win_s;
   logic              strt_cal_r, cal_busy_r;
   logic [LED_W-1:0]  led_r;

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_START;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next-state decode and state qualifiers
   always_comb begin
      state_nxt_s  = state_r;
      show_s       = 1'b0;
      enter_show_s = 1'b0;
      case (state_r)
         ST_START: begin
            state_nxt_s = ST_CAL;
         end
         ST_CAL: begin
            if (cal_done) begin
               state_nxt_s  = ST_SHOW;
               enter_show_s = 1'b1;
            end else begin
               state_nxt_s  = ST_CAL;
               enter_show_s = 1'b0;
            end
         end
         ST_SHOW: begin
            state_nxt_s = ST_SHOW;
            show_s      = 1'b1;
         end
         default: begin
            state_nxt_s = ST_START;
         end
      endcase
   end

   // Auto timer, channel index and peak-clear control
   always_comb begin
      tick_s    = show_s && auto_md && (cnt_r == CNT_LAST);
      adv_s     = show_s && (next || tick_s);
      clr_all_s = enter_show_s || (show_s && clr_pk);
      // The counter runs only while auto-advancing; any advance restarts it.
      if (show_s && auto_md && !next && !tick_s) begin
         cnt_nxt_s = cnt_r + CNT_ONE;
      end else begin
         cnt_nxt_s = CNT_ZERO;
      end
      if (adv_s) begin
         if (ch_idx_r == IDX_LAST) begin
            idx_nxt_s = IDX_ZERO;
         end else begin
            idx_nxt_s = ch_idx_r + IDX_ONE;
         end
      end else begin
         idx_nxt_s = ch_idx_r;
      end
   end

   // Auto timer and channel index registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r    <= CNT_ZERO;
         ch_idx_r <= IDX_ZERO;
      end else begin
         cnt_r    <= cnt_nxt_s;
         ch_idx_r <= idx_nxt_s;
      end
   end

   // Per-channel saturated magnitude of the incoming samples
   always_comb begin
      for (int k = 0; k < NUM_CH; k++) begin
         abs_s[k] = sat_abs(ch_data[k*DATA_W +: DATA_W]);
      end
   end

   // Live sample and peak-hold registers; a clear beats a same-cycle sample
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NUM_CH; k++) begin
            live_r[k] <= LED_ZERO;
            pk_r[k]   <= DATA_ZERO;
         end
      end else begin
         for (int k = 0; k < NUM_CH; k++) begin
            if (vld) begin
               live_r[k] <= ch_data[k*DATA_W + LSB_SEL +: LED_W];
            end else begin
               live_r[k] <= live_r[k];
            end
            if (clr_all_s) begin
               pk_r[k] <= DATA_ZERO;
            end else if (show_s && vld && (abs_s[k] > pk_r[k])) begin
               pk_r[k] <= abs_s[k];
            end else begin
               pk_r[k] <= pk_r[k];
            end
         end
      end
   end

   // Display source select for the current channel
   always_comb begin
      win_s = LED_ZERO;
      for (int k = 0; k < NUM_CH; k++) begin
         win_s = (ch_idx_r == IW'(k)) ?
                 (pk_md ? pk_r[k][LSB_SEL +: LED_W] : live_r[k]) : win_s;
      end
   end

   // Registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         strt_cal_r <= 1'b0;
         cal_busy_r <= 1'b1;
         led_r      <= LED_ZERO;
      end else begin
         strt_cal_r <= (state_r == ST_START);
         cal_busy_r <= (state_nxt_s != ST_SHOW);
         led_r      <= show_s ? win_s : LED_ZERO;
      end
   end

   assign strt_cal = strt_cal_r;
   assign cal_busy = cal_busy_r;
   assign LED      = led_r;
   assign ch_idx   = ch_idx_r;

endmodule

// File: tb/tb_inert_chan_monitor.sv
// -----------------------------------------------------------------------------
// tb_inert_chan_monitor
// Directed bench for inert_chan_monitor with a cycle-level behavioural model.
// Inputs change 1 time unit after the rising edge; outputs are compared on the
// falling edge of every cycle, plus literal checks at chosen points.
// -----------------------------------------------------------------------------
module tb_inert_chan_monitor;

   localparam int NUM_CH   = 3;
   localparam int DATA_W   = 16;
   localparam int LED_W    = 8;
   localparam int LSB_SEL  = 1;
   localparam int AUTO_CYC = 4;

   logic                     clk      = 1'b0;
   logic                     rst_n    = 1'b0;
   logic                     cal_done = 1'b0;
   logic                     vld      = 1'b0;
   logic                     next     = 1'b0;
   logic                     auto_md  = 1'b0;
   logic                     pk_md    = 1'b0;
   logic                     clr_pk   = 1'b0;
   logic [NUM_CH*DATA_W-1:0] ch_data  = '0;
   logic                     strt_cal;
   logic                     cal_busy;
   logic [LED_W-1:0]         LED;
   logic [1:0]               ch_idx;

   int errors    = 0;
   int checks    = 0;
   int strt_seen = 0;

   inert_chan_monitor #(
      .NUM_CH  (NUM_CH),
      .DATA_W  (DATA_W),
      .LED_W   (LED_W),
      .LSB_SEL (LSB_SEL),
      .AUTO_CYC(AUTO_CYC)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .cal_done(cal_done),
      .strt_cal(strt_cal),
      .vld     (vld),
      .ch_data (ch_data),
      .next    (next),
      .auto_md (auto_md),
      .pk_md   (pk_md),
      .clr_pk  (clr_pk),
      .LED     (LED),
      .ch_idx  (ch_idx),
      .cal_busy(cal_busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Signed sample -> magnitude, capped at the largest positive value.
   function automatic int mag(input logic [DATA_W-1:0] v);
      int s;
      s = int'($signed(v));
      if (s < 0) s = -s;
      if (s > 32767) s = 32767;
      return s;
   endfunction

   // ---------------- behavioural model ----------------
   // phase: 0 = calibration start, 1 = waiting for calibration, 2 = showing
   int               m_phase, n_phase;
   int               m_idx, n_idx;
   int               m_elapsed, n_elapsed;
   int               m_pk [NUM_CH];
   int               n_pk [NUM_CH];
   logic [DATA_W-1:0] m_live [NUM_CH];
   logic [DATA_W-1:0] n_live [NUM_CH];
   logic             m_strt, n_strt, m_busy, n_busy;
   logic [LED_W-1:0] m_led, n_led;
   logic [DATA_W-1:0] src;
   logic             tick;

   always_comb begin
      n_phase   = m_phase;
      n_idx     = m_idx;
      n_elapsed = m_elapsed;
      tick      = 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
         n_pk[k]   = m_pk[k];
         n_live[k] = m_live[k];
      end
      n_strt = (m_phase == 0);
      src    = pk_md ? DATA_W'(m_pk[m_idx]) : m_live[m_idx];
      n_led  = (m_phase == 2) ? src[LSB_SEL +: LED_W] : 8'h00;
      if (m_phase == 2 && auto_md) begin
         n_elapsed = m_elapsed + 1;
         tick      = (n_elapsed == AUTO_CYC);
      end
      if (m_phase != 2 || !auto_md || next || tick) n_elapsed = 0;
      if (m_phase == 2 && (next || tick)) n_idx = (m_idx + 1) % NUM_CH;
      for (int k = 0; k < NUM_CH; k++) begin
         if (vld) n_live[k] = ch_data[k*DATA_W +: DATA_W];
         if (m_phase == 2 && clr_pk) n_pk[k] = 0;
         else if (m_phase == 2 && vld && mag(ch_data[k*DATA_W +: DATA_W]) > m_pk[k])
            n_pk[k] = mag(ch_data[k*DATA_W +: DATA_W]);
      end
      if (m_phase == 0) begin
         n_phase = 1;
      end else if (m_phase == 1 && cal_done) begin
         n_phase = 2;
         for (int k = 0; k < NUM_CH; k++) n_pk[k] = 0;
      end
      n_busy = (n_phase != 2);
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_phase   <= 0;
         m_idx     <= 0;
         m_elapsed <= 0;
         m_strt    <= 1'b0;
         m_busy    <= 1'b1;
         m_led     <= 8'h00;
         for (int k = 0; k < NUM_CH; k++) begin
            m_pk[k]   <= 0;
            m_live[k] <= 16'h0000;
         end
      end else begin
         m_phase   <= n_phase;
         m_idx     <= n_idx;
         m_elapsed <= n_elapsed;
         m_strt    <= n_strt;
         m_busy    <= n_busy;
         m_led     <= n_led;
         for (int k = 0; k < NUM_CH; k++) begin
            m_pk[k]   <= n_pk[k];
            m_live[k] <= n_live[k];
         end
      end
   end

   // Every-cycle compare against the model
   always @(negedge clk) begin
      if (strt_cal === 1'b1) strt_seen++;
      chk("strt_cal", 32'(strt_cal), 32'(m_strt));
      chk("cal_busy", 32'(cal_busy), 32'(m_busy));
      chk("LED",      32'(LED),      32'(m_led));
      chk("ch_idx",   32'(ch_idx),   32'(m_idx));
   end

   // ---------------- stimulus ----------------
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic send0(input logic [DATA_W-1:0] d);
      ch_data[DATA_W-1:0] = d;
      vld = 1'b1;
      cyc();
      vld = 1'b0;
   endtask

   task automatic pulse_next();
      next = 1'b1;
      cyc();
      next = 1'b0;
      cyc();
   endtask

   initial begin
      repeat (3) cyc();
      chk("rst_led",  32'(LED),      32'h00);
      chk("rst_busy", 32'(cal_busy), 32'h1);
      chk("rst_strt", 32'(strt_cal), 32'h0);
      chk("rst_idx",  32'(ch_idx),   32'h0);
      rst_n = 1'b1;

      // Calibration with cal_done low for 20 cycles; controls are ignored.
      cyc();
      next = 1'b1; clr_pk = 1'b1; auto_md = 1'b1;
      cyc();
      next = 1'b0; clr_pk = 1'b0;
      ch_data = {16'h1111, 16'h2222, 16'hF234};
      vld = 1'b1;
      cyc();
      vld = 1'b0;
      repeat (17) cyc();
      auto_md = 1'b0;
      chk("cal_led",  32'(LED),      32'h00);
      chk("cal_busy", 32'(cal_busy), 32'h1);
      cal_done = 1'b1;
      cyc();
      chk("show_busy",  32'(cal_busy), 32'h0);
      chk("entry_led",  32'(LED),      32'h00);
      cyc();
      chk("strt_pulses1", 32'(strt_seen), 32'd1);
      chk("live_from_cal", 32'(LED), 32'h1A);

      // Live display and manual channel walk
      ch_data = {16'h0F0F, 16'h00FE, 16'h0102};
      vld = 1'b1;
      cyc();
      vld = 1'b0;
      cyc();
      chk("live_ch0", 32'(LED), 32'h81);
      chk("idx0",     32'(ch_idx), 32'd0);
      pulse_next();
      chk("live_ch1", 32'(LED), 32'h7F);
      chk("idx1",     32'(ch_idx), 32'd1);
      pulse_next();
      chk("live_ch2", 32'(LED), 32'h87);
      chk("idx2",     32'(ch_idx), 32'd2);
      pulse_next();
      chk("idx_wrap", 32'(ch_idx), 32'd0);
      chk("live_wrap", 32'(LED), 32'h81);

      // Peak hold
      pk_md = 1'b1;
      clr_pk = 1'b1;
      cyc();
      clr_pk = 1'b0;
      send0(16'h0010);
      send0(16'hFF00);
      send0(16'h0020);
      cyc();
      chk("pk0_model", 32'(m_pk[0]), 32'h0100);
      chk("pk_led",    32'(LED),     32'h80);
      send0(16'h8000);
      cyc();
      chk("pk0_sat_model", 32'(m_pk[0]), 32'h7FFF);
      chk("pk_sat_led",    32'(LED),     32'hFF);

      // Clear coincident with a sample: the clear wins
      ch_data[DATA_W-1:0] = 16'h0400;
      clr_pk = 1'b1;
      vld = 1'b1;
      cyc();
      clr_pk = 1'b0;
      vld = 1'b0;
      cyc();
      chk("clr_model", 32'(m_pk[0]), 32'h0);
      chk("clr_led",   32'(LED),     32'h00);
      send0(16'h0400);
      cyc();
      chk("reload_model", 32'(m_pk[0]), 32'h0400);
      send0(16'hFC02);
      cyc();
      chk("pk_hold_led", 32'(LED), 32'h00);

      // Auto-advance every AUTO_CYC cycles
      pk_md = 1'b0;
      auto_md = 1'b1;
      repeat (3) cyc();
      chk("auto_hold0", 32'(ch_idx), 32'd0);
      cyc();
      chk("auto_1", 32'(ch_idx), 32'd1);
      repeat (4) cyc();
      chk("auto_2", 32'(ch_idx), 32'd2);
      repeat (4) cyc();
      chk("auto_0", 32'(ch_idx), 32'd0);
      // next mid-period
      repeat (2) cyc();
      next = 1'b1;
      cyc();
      next = 1'b0;
      chk("mid_next", 32'(ch_idx), 32'd1);
      repeat (3) cyc();
      chk("restart_hold", 32'(ch_idx), 32'd1);
      cyc();
      chk("restart_tick", 32'(ch_idx), 32'd2);
      // next coincident with the tick
      repeat (3) cyc();
      next = 1'b1;
      cyc();
      next = 1'b0;
      chk("coincident", 32'(ch_idx), 32'd0);
      repeat (3) cyc();
      chk("coinc_hold", 32'(ch_idx), 32'd0);
      cyc();
      chk("coinc_next", 32'(ch_idx), 32'd1);
      repeat (4) cyc();
      chk("pre_rst_idx", 32'(ch_idx), 32'd2);
      auto_md = 1'b0;
      cyc();
      chk("pre_rst_led", 32'(LED), 32'h87);

      // Asynchronous reset in SHOW
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_led",  32'(LED),      32'h00);
      chk("arst_idx",  32'(ch_idx),   32'd0);
      chk("arst_busy", 32'(cal_busy), 32'h1);
      chk("arst_pk_model", 32'(m_pk[0]), 32'h0);
      cal_done = 1'b0;
      repeat (2) cyc();
      rst_n = 1'b1;
      repeat (5) cyc();
      chk("strt_pulses2", 32'(strt_seen), 32'd2);
      cal_done = 1'b1;
      repeat (2) cyc();
      pk_md = 1'b1;
      repeat (2) cyc();
      chk("pk_after_rst", 32'(LED), 32'h00);
      repeat (2) cyc();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/inert_chan_monitor.md
# inert_chan_monitor

Parametrised successor to the inertial-interface bring-up display: sequences sensor calibration, then presents one of NUM_CH signed inertial channels on the board LEDs. Channels are selected by a debounced NEXT pulse or by timed auto-advance, and each can show either the live sample or a peak-magnitude hold. Sits between the inertial interface (calibration handshake, vld and channel data) and the LED pins on the bring-up top level.

## Interface
- NUM_CH, 3: number of channels (≥1); channel 0 is pitch, 1 roll, 2 yaw.
- DATA_W, 16: signed sample width per channel.
- LED_W, 8: LED bus width; LED_W + LSB_SEL ≤ DATA_W.
- LSB_SEL, 1: lowest sample bit shown on the LEDs.
- AUTO_CYC, 50_000_000: clk cycles per auto-advance step (≥2).
- Index width IW = $clog2(max(NUM_CH,2)).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- cal_done  in  1  calibration-complete level from the inertial interface.
- strt_cal  out  1  single-cycle calibration start pulse.
- vld  in  1  new sample set valid on ch_data (single cycle).
- ch_data  in  NUM_CH*DATA_W  packed samples; channel k occupies bits [k*DATA_W +: DATA_W].
- next  in  1  debounced single-cycle advance request.
- auto_md  in  1  0 = manual advance only; 1 = timed auto-advance, with next still honoured.
- pk_md  in  1  0 = display live sample; 1 = display peak magnitude.
- clr_pk  in  1  single-cycle clear of all peak registers.
- LED  out  LED_W  displayed bit window.
- ch_idx  out  IW  currently displayed channel.
- cal_busy  out  1  high in states START and CAL.

## Operation
- FSM states START, CAL, SHOW. Reset state is START.
- START: assert strt_cal for exactly one cycle, then go to CAL.
- CAL: wait for cal_done = 1, then go to SHOW. next, auto_md and clr_pk are ignored in this state.
- SHOW: stays in SHOW until reset. A later drop of cal_done is ignored.
- Live registers live[k] load ch_data slice k on every vld, in any state.
- Peak registers:
  - On vld in SHOW: pk[k] ← max(pk[k], |sample_k|).
  - The absolute value saturates: the most negative value maps to 2^(DATA_W-1)-1.
  - pk[k] is unsigned, DATA_W wide.
- pk clear: all pk[k] are cleared on entry to SHOW and on clr_pk. If clr_pk and vld occur in the same cycle, the clear wins and pk = 0 that cycle.
- Index advance (SHOW only):
  - next or an auto tick advances ch_idx: ch_idx ← (ch_idx == NUM_CH-1) ? 0 : ch_idx+1.
  - next and an auto tick in the same cycle produce a single advance.
  - If NUM_CH = 1, ch_idx stays 0.
- Auto timer:
  - When auto_md = 1 in SHOW, the counter increments every cycle. At AUTO_CYC-1 it issues a tick and returns to 0.
  - The counter is held at 0 whenever auto_md = 0 or the state is not SHOW.
  - Any next pulse resets the counter to 0.
- Display source: src = pk_md ? pk[ch_idx] : live[ch_idx].
- LED output: LED ← src[LSB_SEL +: LED_W] in SHOW; LED ← 0 in START and CAL.

## Timing
- Reset values:
  - state = START, strt_cal = 0, LED = 0, ch_idx = 0, cal_busy = 1.
  - All live and pk registers = 0; auto counter = 0.
- strt_cal is high in the first clock cycle after rst_n deasserts (registered decode of START).
- cal_done sampled high in cycle n: state = SHOW at n+1, LED valid from n+2.
- All outputs are registered.
  - LED reflects a vld or index change one cycle after the live/pk/ch_idx register update, i.e. two edges after the vld or next.
  - ch_idx updates one edge after next or the tick.
- Auto period: exactly AUTO_CYC cycles between ticks when next is absent.
- If rst_n asserts mid-operation, everything returns to reset values asynchronously. A fresh strt_cal pulse follows the deassertion.

## Test plan
- Reset, hold cal_done = 0 for 20 cycles, then raise it.
  - Required: exactly one strt_cal pulse, in the first cycle after reset release.
  - Required: LED = 0 and cal_busy = 1 until SHOW; cal_busy = 0 from the cycle after cal_done is seen.
- In SHOW, manual mode, vld with ch_data = {16'h0F0F, 16'h00FE, 16'h0102} (ch2, ch1, ch0).
  - Required: LED = 8'h81 at ch_idx 0.
  - After next: LED = 8'h7F at ch_idx 1.
  - After next: LED = 8'h87 at ch_idx 2.
  - After next: ch_idx wraps to 0.
- pk_md = 1, ch0 samples 16'h0010, 16'hFF00 (−256), 16'h0020.
  - Required: pk[0] = 16'h0100 and LED = 8'h80.
  - Then 16'h8000 arrives: pk[0] = 16'h7FFF and LED = 8'hFF.
- clr_pk and vld (ch0 = 16'h0400) in the same cycle → pk[0] = 0 and LED = 0. The next vld then loads pk[0] = 16'h0400.
- AUTO_CYC = 4, auto_md = 1: ch_idx steps every 4 cycles, sequence 0,1,2,0.
  - next mid-period: immediate advance, counter restarts.
  - next coincident with the tick: a single advance.
- Assert rst_n low while in SHOW at ch_idx 2.
  - Required: LED, ch_idx and pk clear immediately and state returns to START.
  - Required: a new strt_cal pulse follows the release.
